// File: rtl/rsa_link_core.sv
// rsa_link_core: RSA loopback. It derives a key pair from two fixed primes.
// Each round it encrypts Message with the public key and then decrypts the
// ciphertext with the private key. Rounds repeat back to back once the keys
// exist.
module rsa_link_core #(
  parameter int P       = 61,
  parameter int Q       = 53,
  parameter int E_START = 3,
  parameter int W       = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Message,
  output logic [W-1:0] n,
  output logic [W-1:0] encrypt_key,
  output logic         donegcd,
  output logic [W-1:0] encrypted_msg,
  output logic         done_encrypt,
  output logic [W-1:0] decrypted_message,
  output logic         done_decrypt
);

  localparam int          CW    = $clog2(W) + 1;
  localparam logic [W-1:0] N_C   = W'(P) * W'(Q);
  localparam logic [W-1:0] PHI_C = (W'(P) - W'(1)) * (W'(Q) - W'(1));

  typedef enum logic [2:0] {
    KEY_INIT, E_SEARCH, D_CALC, ENC_LOAD, ENC_RUN, ENC_DONE, DEC_RUN, DEC_DONE
  } state_t;

  state_t               state;
  logic [W-1:0]         phi, cand, ga, gb, e_r, d_r;
  logic [W-1:0]         r0, r1;
  logic signed [W-1:0]  t0, t1;
  logic [W-1:0]         base, result, exp_r;
  logic [CW-1:0]        cnt;

  logic [W-1:0]         ext_q, mul_rb, mul_bb, msg_red;
  logic signed [W-1:0]  t1_nx;

  // Modular product at double width so no intermediate bits are lost
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  // Shared datapath terms: extended-Euclid quotient/coefficient, multiply-mod, message reduction
  always_comb begin
    ext_q   = (r1 == '0) ? '0 : r0 / r1;
    t1_nx   = t0 - $signed(ext_q) * t1;
    mul_rb  = (n == '0) ? '0 : mulmod(result, base, n);
    mul_bb  = (n == '0) ? '0 : mulmod(base, base, n);
    msg_red = (n == '0) ? '0 : Message % n;
  end

  // Key generation followed by endless encrypt/decrypt rounds
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= KEY_INIT;
      phi               <= '0;
      cand              <= '0;
      ga                <= '0;
      gb                <= '0;
      e_r               <= '0;
      d_r               <= '0;
      r0                <= '0;
      r1                <= '0;
      t0                <= '0;
      t1                <= '0;
      base              <= '0;
      result            <= '0;
      exp_r             <= '0;
      cnt               <= '0;
      n                 <= '0;
      encrypt_key       <= '0;
      donegcd           <= 1'b0;
      encrypted_msg     <= '0;
      done_encrypt      <= 1'b0;
      decrypted_message <= '0;
      done_decrypt      <= 1'b0;
    end else begin
      done_encrypt <= 1'b0;
      done_decrypt <= 1'b0;
      case (state)
        KEY_INIT: begin
          n     <= N_C;
          phi   <= PHI_C;
          cand  <= W'(E_START);
          ga    <= PHI_C;
          gb    <= W'(E_START);
          state <= E_SEARCH;
        end
        // One Euclid remainder step per cycle; gb==0 means ga holds the gcd
        E_SEARCH: begin
          if (gb == '0) begin
            if (ga == W'(1)) begin
              e_r   <= cand;
              r0    <= phi;
              r1    <= cand;
              t0    <= '0;
              t1    <= W'(1);
              state <= D_CALC;
            end else begin
              cand <= cand + W'(2);
              ga   <= phi;
              gb   <= cand + W'(2);
            end
          end else begin
            ga <= gb;
            gb <= ga % gb;
          end
        end
        // Extended Euclid tracking only the coefficient of e
        D_CALC: begin
          if (r1 == '0) begin
            d_r         <= t0[W-1] ? $unsigned(t0) + phi : $unsigned(t0);
            encrypt_key <= e_r;
            donegcd     <= 1'b1;
            state       <= ENC_LOAD;
          end else begin
            r0 <= r1;
            r1 <= r0 - ext_q * r1;
            t0 <= t1;
            t1 <= t1_nx;
          end
        end
        ENC_LOAD: begin
          base   <= msg_red;
          result <= W'(1);
          exp_r  <= e_r;
          cnt    <= '0;
          state  <= ENC_RUN;
        end
        ENC_RUN, DEC_RUN: begin
          if (exp_r[0]) result <= mul_rb;
          base  <= mul_bb;
          exp_r <= exp_r >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= (state == ENC_RUN) ? ENC_DONE : DEC_DONE;
        end
        // Publish the ciphertext and load the decrypt run in the same cycle
        ENC_DONE: begin
          encrypted_msg <= result;
          done_encrypt  <= 1'b1;
          base          <= result;
          result        <= W'(1);
          exp_r         <= d_r;
          cnt           <= '0;
          state         <= DEC_RUN;
        end
        DEC_DONE: begin
          decrypted_message <= result;
          done_decrypt      <= 1'b1;
          state             <= ENC_LOAD;
        end
        default: state <= KEY_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_link_core.sv
// tb_rsa_link_core: directed checks of key generation, round values/timing,
// boundary messages and mid-round reset, with hand-computed expectations.
module tb_rsa_link_core;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] Message;
  logic [W-1:0] n, encrypt_key, encrypted_msg, decrypted_message;
  logic         donegcd, done_encrypt, done_decrypt;

  int total = 0;
  int bad   = 0;

  rsa_link_core #(.P(61), .Q(53), .E_START(3), .W(W)) dut (
    .clk(clk), .rst(rst), .Message(Message), .n(n), .encrypt_key(encrypt_key),
    .donegcd(donegcd), .encrypted_msg(encrypted_msg), .done_encrypt(done_encrypt),
    .decrypted_message(decrypted_message), .done_decrypt(done_decrypt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_keys();
    int c = 0;
    do begin @(negedge clk); c++; end while (!donegcd && c < 1000);
    chk("keygen_done", {63'd0, donegcd}, 64'd1);
    chk("n", n, 64'd3233);
    chk("e", encrypt_key, 64'd7);
  endtask

  // Called at a negedge where the next posedge is ENC_LOAD
  task automatic run_round(input string tag, input logic [W-1:0] msg,
                           input bit chk_enc, input logic [W-1:0] exp_enc,
                           input logic [W-1:0] exp_dec);
    int c = 0;
    Message = msg;
    do begin
      @(negedge clk); c++;
      if (c == 5) Message = msg ^ 64'h5a5;   // mid-round change must be ignored
      chk({tag, "_no_dec_early"}, {63'd0, done_decrypt}, 64'd0);
    end while (!done_encrypt && c < 400);
    chk({tag, "_enc_lat"}, 64'(c), 64'(W + 2));
    if (chk_enc) chk({tag, "_enc"}, encrypted_msg, exp_enc);
    c = 0;
    do begin
      @(negedge clk); c++;
      chk({tag, "_no_enc_overlap"}, {63'd0, done_encrypt}, 64'd0);
    end while (!done_decrypt && c < 400);
    chk({tag, "_dec_lat"}, 64'(c), 64'(W + 1));
    chk({tag, "_dec"}, decrypted_message, exp_dec);
    chk({tag, "_keys_hold"}, {63'd0, donegcd}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] seq [5];
    seq = '{64'd2321, 64'd542, 64'd1580, 64'd1453, 64'd874};
    rst = 1'b1;
    Message = 64'd8;
    repeat (2) @(negedge clk);
    chk("rst_n", n, 64'd0);
    chk("rst_e", encrypt_key, 64'd0);
    chk("rst_donegcd", {63'd0, donegcd}, 64'd0);
    chk("rst_enc", encrypted_msg, 64'd0);
    chk("rst_dec", decrypted_message, 64'd0);
    chk("rst_pulses", {62'd0, done_encrypt, done_decrypt}, 64'd0);
    rst = 1'b0;
    wait_keys();

    run_round("m8", 64'd8, 1'b1, 64'd2168, 64'd8);
    run_round("m2", 64'd2, 1'b1, 64'd128, 64'd2);
    run_round("m0", 64'd0, 1'b1, 64'd0, 64'd0);
    run_round("m1", 64'd1, 1'b1, 64'd1, 64'd1);
    for (int i = 0; i < 5; i++) begin
      run_round("seq_a", seq[i], 1'b0, 64'd0, seq[i]);
      run_round("seq_b", seq[i], 1'b0, 64'd0, seq[i]);
    end
    run_round("over", 64'd3238, 1'b1, 64'd533, 64'd5);

    // Abort during DEC_RUN
    Message = 64'd8;
    begin
      int c = 0;
      do begin @(negedge clk); c++; end while (!done_encrypt && c < 400);
      chk("pre_abort_enc", encrypted_msg, 64'd2168);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_n", n, 64'd0);
    chk("abort_e", encrypt_key, 64'd0);
    chk("abort_donegcd", {63'd0, donegcd}, 64'd0);
    chk("abort_enc", encrypted_msg, 64'd0);
    chk("abort_dec", decrypted_message, 64'd0);
    rst = 1'b0;
    wait_keys();
    run_round("resume", 64'd8, 1'b1, 64'd2168, 64'd8);
    run_round("resume2", 64'd2, 1'b1, 64'd128, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
